// File: rtl/mem_loader.sv
// Byte-stream to word-write loader for the instruction memory.
// Optional trailing checksum byte when MEM_LOADER_CHECKSUM_EN is defined.
module mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] ONE = 1;
  localparam logic [ADDR_WIDTH:0] ZERO = '0;

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, CHECK, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, DONE
  } state_t;
`endif

  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [1:0]            byte_cnt;
  logic [31:0]           asm_q;
  logic                  xfer;
  logic                  last_word;

  assign xfer = in_valid && in_ready;
  assign last_word = (word_cnt == (num_q - ONE));

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          nxt = (num_words == ZERO) ? DONE : RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer && byte_cnt == 2'd3)
          nxt = WRITE;
        if (abort)
          nxt = IDLE;
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (last_word)
`ifdef MEM_LOADER_CHECKSUM_EN
          nxt = CHECK;
`else
          nxt = DONE;
`endif
        else
          nxt = RECV;
        if (abort)
          nxt = IDLE;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer)
          nxt = DONE;
        if (abort)
          nxt = IDLE;
      end
`endif
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      num_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        word_cnt <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
      end
      if (state == RECV && xfer) begin
        asm_q[{byte_cnt, 3'b000} +: 8] <= in_data;
        byte_cnt <= byte_cnt + 2'd1;
        // Output regs load on entry to WRITE so they hold afterwards
        if (byte_cnt == 2'd3 && !abort) begin
          wr_addr <= base_q + word_cnt[ADDR_WIDTH-1:0];
          wr_data <= {in_data, asm_q[23:0]};
        end
      end
      if (state == WRITE)
        word_cnt <= word_cnt + ONE;
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sum_q <= '0;
        err_q <= 1'b0;
      end
      if (state == RECV && xfer)
        sum_q <= sum_q + in_data;
      if (state == CHECK && xfer && !abort)
        err_q <= ((sum_q + in_data) != 8'd0);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: loads, gaps, wrap, abort, reset.
// Checksum scenarios run when MEM_LOADER_CHECKSUM_EN is defined.
module tb_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  num_words = '0;

  logic        in_ready, wr_en, busy, done, err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  logic        in_ready4, wr_en4, busy4, done4, err4;
  logic [3:0]  wr_addr4;
  logic [31:0] wr_data4;

  int total = 0;
  int bad = 0;
  int nw = 0;
  int nd = 0;
  int ovl = 0;

  mem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  mem_loader #(.ADDR_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr[3:0]), .num_words(num_words[4:0]),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .wr_en(wr_en4),
    .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .err(err4)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) nw++;
    if (done) nd++;
    if (wr_en && in_ready) ovl++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [8:0] n);
    start = 1'b1;
    base_addr = b;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic ok;
    int k;
    ok = 1'b0;
    k = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!ok && k < 50) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      k++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout byte=%h", b);
    end
    repeat (gap) tick();
  endtask

  task automatic send_last(
    input  logic [7:0]  b,
    output logic        we,
    output logic [7:0]  wa,
    output logic [31:0] wd,
    output logic        rdy,
    output logic [3:0]  wa4,
    output logic [31:0] wd4
  );
    send_byte(b, 0);
    @(negedge clk);
    we = wr_en;
    wa = wr_addr;
    wd = wr_data;
    rdy = in_ready;
    wa4 = wr_addr4;
    wd4 = wr_data4;
    tick();
  endtask

  task automatic send_word(
    input  logic [31:0] w,
    input  int          gap,
    output logic        we,
    output logic [7:0]  wa,
    output logic [31:0] wd,
    output logic        rdy,
    output logic [3:0]  wa4,
    output logic [31:0] wd4
  );
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_last(w[31:24], we, wa, wd, rdy, wa4, wd4);
  endtask

  task automatic finish_tail(input logic [7:0] cs);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(cs, 0);
`else
    if (cs === 8'hxx) $display("unused checksum");
`endif
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {in_ready, wr_en, busy, done, err});
    end
    total++;
    if (wr_addr !== 8'h00 || wr_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h want=00/0",
               wr_addr, wr_data);
    end
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b rdy=%b want 0/0",
               busy, in_ready);
    end
    tick();
  endtask

  task automatic test_basic();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    int nw0, nd0;
    nw0 = nw;
    nd0 = nd;
    do_start(8'h10, 9'd2);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_recv busy=%b rdy=%b want 1/1",
               busy, in_ready);
    end
    tick();
    send_word(32'h12345678, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || wa !== 8'h10 || wd !== 32'h12345678) begin
      bad++;
      $display("FAIL basic_w0 got=%b %h %h want=1 10 12345678",
               we, wa, wd);
    end
    send_word(32'hDEADBEEF, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || wa !== 8'h11 || wd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_w1 got=%b %h %h want=1 11 deadbeef",
               we, wa, wd);
    end
    finish_tail(8'hB4);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done done=%b busy=%b want 1/0",
               done, busy);
    end
    tick();
    @(negedge clk);
    total++;
    if (done !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse done=%b wr_en=%b want 0/0",
               done, wr_en);
    end
    total++;
    if (wr_addr !== 8'h11 || wr_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_hold got=%h %h want=11 deadbeef",
               wr_addr, wr_data);
    end
    total++;
    if (nw - nw0 !== 2 || nd - nd0 !== 1) begin
      bad++;
      $display("FAIL basic_counts writes=%0d dones=%0d want 2/1",
               nw - nw0, nd - nd0);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    int nw0, nd0, ov0;
    nw0 = nw;
    nd0 = nd;
    ov0 = ovl;
    do_start(8'h10, 9'd2);
    repeat (3) tick();
    send_word(32'h12345678, 3, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || rdy !== 1'b0 || wa !== 8'h10 ||
        wd !== 32'h12345678) begin
      bad++;
      $display("FAIL gap_w0 got=%b %b %h %h want=1 0 10 12345678",
               we, rdy, wa, wd);
    end
    repeat (3) tick();
    send_word(32'hDEADBEEF, 3, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || rdy !== 1'b0 || wa !== 8'h11 ||
        wd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL gap_w1 got=%b %b %h %h want=1 0 11 deadbeef",
               we, rdy, wa, wd);
    end
    finish_tail(8'hB4);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL gap_done got=%b want=1", done);
    end
    tick();
    total++;
    if (nw - nw0 !== 2 || ovl - ov0 !== 0 || nd - nd0 !== 1) begin
      bad++;
      $display("FAIL gap_counts w=%0d ovl=%0d d=%0d want 2/0/1",
               nw - nw0, ovl - ov0, nd - nd0);
    end
  endtask

  task automatic test_wrap();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    do_start(8'h0F, 9'd2);
    send_word(32'h00000001, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (wa4 !== 4'hF || wd4 !== 32'h1) begin
      bad++;
      $display("FAIL wrap_w0 got=%h %h want=f 00000001", wa4, wd4);
    end
    send_word(32'h00000002, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (wa4 !== 4'h0 || wd4 !== 32'h2) begin
      bad++;
      $display("FAIL wrap_w1 got=%h %h want=0 00000002", wa4, wd4);
    end
    total++;
    if (wa !== 8'h10) begin
      bad++;
      $display("FAIL wrap_wide got=%h want=10", wa);
    end
    finish_tail(8'hFD);
    tick();
  endtask

  task automatic test_zero_and_ignored_start();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    int nw0, nd0;
    nw0 = nw;
    nd0 = nd;
    do_start(8'h33, 9'd0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      bad++;
      $display("FAIL zero_done got=%b%b%b want=100",
               done, busy, wr_en);
    end
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL zero_err got=%b want=0", err);
    end
    repeat (2) tick();
    total++;
    if (nw - nw0 !== 0 || nd - nd0 !== 1) begin
      bad++;
      $display("FAIL zero_counts w=%0d d=%0d want 0/1",
               nw - nw0, nd - nd0);
    end
    do_start(8'h20, 9'd1);
    send_byte(8'hD4, 0);
    send_byte(8'hC3, 0);
    do_start(8'h30, 9'd3);
    send_byte(8'hB2, 0);
    send_last(8'hA1, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || wa !== 8'h20 || wd !== 32'hA1B2C3D4) begin
      bad++;
      $display("FAIL ignored_start got=%b %h %h want=1 20 a1b2c3d4",
               we, wa, wd);
    end
    finish_tail(8'h16);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ignored_no_relatch done=%b want=1", done);
    end
    tick();
  endtask

  task automatic test_abort();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    int nw0, nd0;
    nw0 = nw;
    nd0 = nd;
    do_start(8'h40, 9'd1);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle busy=%b rdy=%b want 0/0",
               busy, in_ready);
    end
    repeat (4) tick();
    total++;
    if (nw - nw0 !== 0 || nd - nd0 !== 0) begin
      bad++;
      $display("FAIL abort_quiet w=%0d d=%0d want 0/0",
               nw - nw0, nd - nd0);
    end
    do_start(8'h50, 9'd1);
    send_word(32'h11223344, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || wa !== 8'h50 || wd !== 32'h11223344) begin
      bad++;
      $display("FAIL abort_reload got=%b %h %h want=1 50 11223344",
               we, wa, wd);
    end
    finish_tail(8'h56);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL abort_reload_done got=%b want=1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
    do_start(8'h60, 9'd2);
    send_byte(8'h99, 0);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, wr_en, busy, done, err} !== 5'b0 ||
        wr_addr !== 8'h00 || wr_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid got=%b %h %h want=00000 00 0",
               {in_ready, wr_en, busy, done, err}, wr_addr, wr_data);
    end
    tick();
    rst = 1'b0;
    do_start(8'h05, 9'd1);
    send_word(32'hCAFEF00D, 0, we, wa, wd, rdy, wa4, wd4);
    total++;
    if (we !== 1'b1 || wa !== 8'h05 || wd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL reset_reload got=%b %h %h want=1 05 cafef00d",
               we, wa, wd);
    end
    finish_tail(8'h3B);
    tick();
  endtask

  task automatic test_checksum();
    logic we, rdy;
    logic [7:0] wa;
    logic [31:0] wd, wd4;
    logic [3:0] wa4;
`ifdef MEM_LOADER_CHECKSUM_EN
    do_start(8'h00, 9'd1);
    send_word(32'h04030201, 0, we, wa, wd, rdy, wa4, wd4);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL cs_check_state rdy=%b busy=%b done=%b want 1/1/0",
               in_ready, busy, done);
    end
    tick();
    send_byte(8'hF6, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL cs_good done=%b err=%b want 1/0", done, err);
    end
    tick();
    do_start(8'h00, 9'd1);
    send_word(32'h04030201, 0, we, wa, wd, rdy, wa4, wd4);
    send_byte(8'h00, 0);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b1) begin
      bad++;
      $display("FAIL cs_bad done=%b err=%b want 1/1", done, err);
    end
    repeat (3) tick();
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL cs_hold err=%b want=1", err);
    end
    do_start(8'h00, 9'd1);
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL cs_clear err=%b want=0", err);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
`else
    do_start(8'h00, 9'd1);
    send_word(32'h04030201, 0, we, wa, wd, rdy, wa4, wd4);
    @(negedge clk);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || we !== 1'b1 ||
        wd !== 32'h04030201) begin
      bad++;
      $display("FAIL err_tied done=%b err=%b we=%b wd=%h want 1/0/1/04030201",
               done, err, we, wd);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_ignored_start();
    test_abort();
    test_reset_mid();
    test_checksum();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
